// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter/rotator, one bit position per clock.
// start is accepted only in IDLE. The operand then steps through SHIFT once
// per cycle, and the result and flags are published on the edge into DONE.
module seq_shifter #(
  parameter  int WIDTH = 8,
  localparam int SW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SW-1:0]    SHAMT,
  input  logic [2:0]       MODE,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OVR,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_LSL = 3'b000;
  localparam logic [2:0] M_LSR = 3'b001;
  localparam logic [2:0] M_ASR = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] r, r_nxt;
  logic [SW-1:0]    cnt;
  logic [2:0]       md;
  logic             co_q, co_nxt;
  logic             ovr_q, ovr_nxt;
  logic [SW-1:0]    cnt_ld;

  // Clamp the count to WIDTH. A reserved mode loads zero steps, so A passes through.
  always_comb begin
    cnt_ld = SHAMT;
    if (SHAMT > SW'(WIDTH)) cnt_ld = SW'(WIDTH);
    if (MODE > M_ROR)       cnt_ld = '0;
  end

  // One step of the working register in the latched mode; OVR is sticky.
  always_comb begin
    r_nxt   = r;
    co_nxt  = co_q;
    ovr_nxt = ovr_q;
    case (md)
      M_LSL: begin
        r_nxt  = {r[WIDTH-2:0], 1'b0};
        co_nxt = r[WIDTH-1];
        if (r[WIDTH-1] != r[WIDTH-2]) ovr_nxt = 1'b1;
      end
      M_LSR: begin
        r_nxt  = {1'b0, r[WIDTH-1:1]};
        co_nxt = r[0];
      end
      M_ASR: begin
        r_nxt  = {r[WIDTH-1], r[WIDTH-1:1]};
        co_nxt = r[0];
      end
      M_ROL: begin
        r_nxt  = {r[WIDTH-2:0], r[WIDTH-1]};
        co_nxt = r[WIDTH-1];
      end
      M_ROR: begin
        r_nxt  = {r[0], r[WIDTH-1:1]};
        co_nxt = r[0];
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, step while counting, publish on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r     <= '0;
      cnt   <= '0;
      md    <= M_LSL;
      co_q  <= 1'b0;
      ovr_q <= 1'b0;
      Y     <= '0;
      CO    <= 1'b0;
      OVR   <= 1'b0;
      Z     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          r     <= A;
          cnt   <= cnt_ld;
          md    <= MODE;
          co_q  <= 1'b0;
          ovr_q <= 1'b0;
        end
        SHIFT: begin
          if (cnt != '0) begin
            r     <= r_nxt;
            co_q  <= co_nxt;
            ovr_q <= ovr_nxt;
            cnt   <= cnt - SW'(1);
          end else begin
            Y   <= r;
            CO  <= co_q;
            OVR <= ovr_q;
            Z   <= (r == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
